// File: rtl/gs_pkg.sv
// Shared definitions for the grouped update sequencer.
//   state_t  : sequencer FSM states (IDLE, RUN, SNAP, DONE)
//   GRP_W    : width of the group code fed to the update-order decoder
//   GRP0..GRP3, GRP_AUX : group codes understood by the decoder
package gs_pkg;

  localparam int GRP_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_SNAP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [GRP_W-1:0] GRP0    = 3'b000;
  localparam logic [GRP_W-1:0] GRP1    = 3'b001;
  localparam logic [GRP_W-1:0] GRP2    = 3'b010;
  localparam logic [GRP_W-1:0] GRP3    = 3'b011;
  localparam logic [GRP_W-1:0] GRP_AUX = 3'b100;

endpackage

// File: rtl/grouped_update_sequencer_if.sv
// Control/status bundle between a run controller and the grouped update
// sequencer.
//   start, stop, num_sweeps : run requests from the controller
//   group_EN, group_valid   : group code and its qualifier for the decoder
//   sample_stb, sweep_cnt   : sweep-boundary strobe and completed sweeps
//   busy, done              : run status
// Modport master = controller side, slave = sequencer side.
interface grouped_update_sequencer_if #(
  parameter int SWEEP_W = 16
) ();
  import gs_pkg::*;

  logic               start;
  logic               stop;
  logic [SWEEP_W-1:0] num_sweeps;
  logic [0:GRP_W-1]   group_EN;
  logic               group_valid;
  logic               sample_stb;
  logic [SWEEP_W-1:0] sweep_cnt;
  logic               busy;
  logic               done;

  modport master (
    output start, stop, num_sweeps,
    input  group_EN, group_valid, sample_stb, sweep_cnt, busy, done
  );

  modport slave (
    input  start, stop, num_sweeps,
    output group_EN, group_valid, sample_stb, sweep_cnt, busy, done
  );

endinterface

// File: rtl/dwell_counter.sv
// Modulo-DWELL_CYCLES counter that times how long one group stays selected.
//   clk, rst : clock and synchronous active-high reset
//   clr      : force the count to 0 (takes priority over en)
//   en       : advance the count this cycle
//   tc       : high in the enabled cycle where the count is DWELL_CYCLES-1
module dwell_counter #(
  parameter int DWELL_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q;

  assign tc = en && (cnt_q == CNT_W'(DWELL_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tc ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/grouped_update_sequencer.sv
// Drives the group select of the p-bit grouped update-order decoder.
// Each run visits groups 0..NUM_GROUPS-1 (plus the auxiliary group when
// AUX_EN) for DWELL_CYCLES cycles each, then spends one SNAP cycle with a
// readout strobe, and repeats until num_sweeps sweeps are done or a stop
// request has been seen (0 sweeps = run until stopped).
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of grouped_update_sequencer_if
// Every output is a flop; the output process computes next-cycle values.
module grouped_update_sequencer
  import gs_pkg::*;
#(
  parameter int NUM_GROUPS   = 4,
  parameter bit AUX_EN       = 1'b1,
  parameter int DWELL_CYCLES = 8,
  parameter int SWEEP_W      = 16
) (
  input logic                      clk,
  input logic                      rst,
  grouped_update_sequencer_if.slave bus
);

  localparam logic [GRP_W-1:0] LAST_COLOUR = GRP_W'(NUM_GROUPS - 1);
  localparam logic [GRP_W-1:0] LAST_GRP    = AUX_EN ? GRP_AUX : LAST_COLOUR;

  state_t             state, state_n;
  logic [GRP_W-1:0]   grp_q, grp_n;
  logic [SWEEP_W-1:0] sweep_q, sweep_n;
  logic [SWEEP_W-1:0] nsw_q, nsw_n;
  logic               stop_q, stop_n;
  logic               valid_q, valid_n;
  logic               stb_q, stb_n;
  logic               busy_q, busy_n;
  logic               done_q, done_n;

  logic dwell_clr, dwell_en, dwell_tc;
  logic at_last;

  function automatic logic [SWEEP_W-1:0] sat_inc(input logic [SWEEP_W-1:0] v);
    return (&v) ? v : v + SWEEP_W'(1);
  endfunction

  // The auxiliary code follows the last colour group; it is only reached
  // when AUX_EN, because otherwise the last colour group ends the sweep.
  function automatic logic [GRP_W-1:0] next_grp(input logic [GRP_W-1:0] g);
    return (g == LAST_COLOUR) ? GRP_AUX : g + GRP_W'(1);
  endfunction

  assign dwell_en  = (state == ST_RUN);
  assign dwell_clr = (state != ST_RUN);
  assign at_last   = (grp_q == LAST_GRP);

  dwell_counter #(
    .DWELL_CYCLES(DWELL_CYCLES)
  ) u_dwell (
    .clk(clk),
    .rst(rst),
    .clr(dwell_clr),
    .en (dwell_en),
    .tc (dwell_tc)
  );

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      grp_q   <= GRP0;
      sweep_q <= '0;
      nsw_q   <= '0;
      stop_q  <= 1'b0;
      valid_q <= 1'b0;
      stb_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      grp_q   <= grp_n;
      sweep_q <= sweep_n;
      nsw_q   <= nsw_n;
      stop_q  <= stop_n;
      valid_q <= valid_n;
      stb_q   <= stb_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (bus.start) state_n = ST_RUN;
      ST_RUN:  if (dwell_tc && at_last) state_n = ST_SNAP;
      ST_SNAP: begin
        // sweep_q already holds the incremented count during SNAP
        if (stop_q || ((nsw_q != '0) && (sweep_q == nsw_q))) state_n = ST_DONE;
        else                                                   state_n = ST_RUN;
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    grp_n   = grp_q;
    sweep_n = sweep_q;
    nsw_n   = nsw_q;
    stop_n  = stop_q;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          grp_n   = GRP0;
          sweep_n = '0;
          nsw_n   = bus.num_sweeps;
          stop_n  = 1'b0;
        end
      end
      ST_RUN: begin
        stop_n = stop_q | bus.stop;
        if (dwell_tc) begin
          if (at_last) sweep_n = sat_inc(sweep_q);
          else         grp_n   = next_grp(grp_q);
        end
      end
      ST_SNAP: begin
        if (state_n == ST_RUN) grp_n = GRP0;
      end
      default: ;
    endcase
    valid_n = (state_n == ST_RUN);
    stb_n   = (state_n == ST_SNAP);
    done_n  = (state_n == ST_DONE);
    busy_n  = (state_n != ST_IDLE);
  end

  assign bus.group_EN    = grp_q;
  assign bus.group_valid = valid_q;
  assign bus.sample_stb  = stb_q;
  assign bus.sweep_cnt   = sweep_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_grouped_update_sequencer.sv
// Directed bench for grouped_update_sequencer. Two instances:
//   dut_a : NUM_GROUPS=4, AUX_EN=1, DWELL_CYCLES=8 (sweep = 41 cycles)
//   dut_b : NUM_GROUPS=4, AUX_EN=0, DWELL_CYCLES=1 (sweep = 5 cycles)
// Inputs change and outputs are observed on the falling edge; "k" counts
// observed cycles after the cycle in which start was sampled.
module tb_grouped_update_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  grouped_update_sequencer_if #(.SWEEP_W(16)) ifa ();
  grouped_update_sequencer_if #(.SWEEP_W(16)) ifb ();

  grouped_update_sequencer #(
    .NUM_GROUPS(4), .AUX_EN(1'b1), .DWELL_CYCLES(8), .SWEEP_W(16)
  ) dut_a (
    .clk(clk), .rst(rst), .bus(ifa)
  );

  grouped_update_sequencer #(
    .NUM_GROUPS(4), .AUX_EN(1'b0), .DWELL_CYCLES(1), .SWEEP_W(16)
  ) dut_b (
    .clk(clk), .rst(rst), .bus(ifb)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Invariants checked every cycle on both instances
  logic pa = 1'b0;
  logic pb = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      pa = 1'b0;
      pb = 1'b0;
    end else begin
      chk("a_gv_excl", 32'(ifa.group_valid & (ifa.sample_stb | ifa.done | ~ifa.busy)), 0);
      chk("a_code_ok", (ifa.group_EN <= 3'd4) ? 1 : 0, 1);
      chk("a_stb_width", 32'(ifa.sample_stb & pa), 0);
      pa = ifa.sample_stb;
      chk("b_gv_excl", 32'(ifb.group_valid & (ifb.sample_stb | ifb.done | ~ifb.busy)), 0);
      chk("b_code_ok", (ifb.group_EN <= 3'd3) ? 1 : 0, 1);
      chk("b_stb_width", 32'(ifb.sample_stb & pb), 0);
      pb = ifb.sample_stb;
    end
  end

  task automatic start_a(input logic [15:0] n);
    ifa.num_sweeps = n;
    ifa.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
  endtask

  task automatic start_b(input logic [15:0] n);
    ifb.num_sweeps = n;
    ifb.start = 1'b1;
    @(negedge clk);
    ifb.start = 1'b0;
  endtask

  initial begin
    int stb_n;
    int stb_k;
    int stb_cnt;
    int done_k;

    ifa.start = 1'b0; ifa.stop = 1'b0; ifa.num_sweeps = '0;
    ifb.start = 1'b0; ifb.stop = 1'b0; ifb.num_sweeps = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_grp",   32'(ifa.group_EN), 0);
    chk("rst_gv",    32'(ifa.group_valid), 0);
    chk("rst_stb",   32'(ifa.sample_stb), 0);
    chk("rst_cnt",   32'(ifa.sweep_cnt), 0);
    chk("rst_busy",  32'(ifa.busy), 0);
    chk("rst_done",  32'(ifa.done), 0);

    // Test 1: two sweeps over groups 0..4, dwell 8
    start_a(16'd2);
    stb_n = 0; done_k = 0;
    for (int k = 1; k <= 84; k++) begin
      if (k <= 82 && ((k - 1) % 41) < 40) begin
        chk("t1_grp", 32'(ifa.group_EN), ((k - 1) % 41) / 8);
        chk("t1_gv", 32'(ifa.group_valid), 1);
      end
      if (ifa.sample_stb) begin
        stb_n++;
        chk("t1_cnt_at_stb", 32'(ifa.sweep_cnt), stb_n);
      end
      if (ifa.done && done_k == 0) done_k = k;
      if (k == 84) begin
        chk("t1_busy_after", 32'(ifa.busy), 0);
        chk("t1_cnt_hold", 32'(ifa.sweep_cnt), 2);
      end
      @(negedge clk);
    end
    chk("t1_stb_pulses", stb_n, 2);
    chk("t1_done_cycle", done_k, 83);

    // Test 2: unlimited sweeps, stop during group 2 of sweep 3
    start_a(16'd0);
    stb_n = 0; stb_k = 0; stb_cnt = 0; done_k = 0;
    for (int k = 1; k <= 130; k++) begin
      if (k == 103) chk("t2_stop_grp", 32'(ifa.group_EN), 2);
      ifa.stop = (k == 103);
      if (ifa.sample_stb) begin
        stb_n++;
        stb_k = k;
        stb_cnt = 32'(ifa.sweep_cnt);
      end
      if (ifa.done && done_k == 0) done_k = k;
      @(negedge clk);
    end
    ifa.stop = 1'b0;
    chk("t2_stb_pulses", stb_n, 3);
    chk("t2_last_stb_k", stb_k, 123);
    chk("t2_cnt_at_stb", stb_cnt, 3);
    chk("t2_done_cycle", done_k, 124);
    chk("t2_idle_busy", 32'(ifa.busy), 0);
    chk("t2_cnt_hold", 32'(ifa.sweep_cnt), 3);

    // Test 3: dwell 1, no aux group, one sweep
    start_b(16'd1);
    for (int k = 1; k <= 4; k++) begin
      chk("t3_grp", 32'(ifb.group_EN), k - 1);
      chk("t3_gv", 32'(ifb.group_valid), 1);
      @(negedge clk);
    end
    chk("t3_snap_stb", 32'(ifb.sample_stb), 1);
    chk("t3_snap_cnt", 32'(ifb.sweep_cnt), 1);
    chk("t3_snap_done", 32'(ifb.done), 0);
    @(negedge clk);
    chk("t3_done", 32'(ifb.done), 1);
    chk("t3_done_busy", 32'(ifb.busy), 1);
    @(negedge clk);
    chk("t3_after_done", 32'(ifb.done), 0);
    chk("t3_after_busy", 32'(ifb.busy), 0);

    // Test 4: reset while in group 2, then a normal run
    start_a(16'd5);
    repeat (16) @(negedge clk);
    chk("t4_pre_grp", 32'(ifa.group_EN), 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t4_rst_grp",  32'(ifa.group_EN), 0);
    chk("t4_rst_gv",   32'(ifa.group_valid), 0);
    chk("t4_rst_stb",  32'(ifa.sample_stb), 0);
    chk("t4_rst_cnt",  32'(ifa.sweep_cnt), 0);
    chk("t4_rst_busy", 32'(ifa.busy), 0);
    chk("t4_rst_done", 32'(ifa.done), 0);
    @(negedge clk);
    chk("t4_no_done", 32'(ifa.done), 0);
    start_a(16'd1);
    done_k = 0;
    for (int k = 1; k <= 43; k++) begin
      if (ifa.done && done_k == 0) done_k = k;
      @(negedge clk);
    end
    chk("t4_done_cycle", done_k, 42);
    chk("t4_cnt", 32'(ifa.sweep_cnt), 1);

    // Test 5: start while busy and in the done cycle are ignored
    start_b(16'd1);
    done_k = 0;
    for (int k = 1; k <= 7; k++) begin
      if (ifb.done && done_k == 0) done_k = k;
      if (k == 7) begin
        chk("t5_idle_busy", 32'(ifb.busy), 0);
        chk("t5_idle_gv", 32'(ifb.group_valid), 0);
        chk("t5_cnt_kept", 32'(ifb.sweep_cnt), 1);
      end
      ifb.start = (k == 2 || k == 6 || k == 7);
      ifb.num_sweeps = (k == 7) ? 16'd1 : 16'd3;
      @(negedge clk);
    end
    ifb.start = 1'b0;
    chk("t5_done_cycle", done_k, 6);
    chk("t5_new_gv", 32'(ifb.group_valid), 1);
    chk("t5_new_grp", 32'(ifb.group_EN), 0);
    chk("t5_new_cnt", 32'(ifb.sweep_cnt), 0);
    chk("t5_new_busy", 32'(ifb.busy), 1);
    done_k = 0;
    for (int k = 1; k <= 8; k++) begin
      if (ifb.done && done_k == 0) done_k = k;
      @(negedge clk);
    end
    chk("t5_new_done_cycle", done_k, 6);
    chk("t5_new_final_cnt", 32'(ifb.sweep_cnt), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/grouped_update_sequencer.md
# grouped_update_sequencer

Scheduler that drives the 3-bit group select into the grouped update-order decoder of the p-bit integer-factorization core. It steps through the graph-colour groups in a fixed order, holding each group for a programmable dwell so that neighbouring p-bit inputs settle. After each full sweep it raises a snapshot strobe for readout, and it stops after a requested number of sweeps.

## Interface
- NUM_GROUPS, 4: colour groups visited per sweep, with codes 0 to NUM_GROUPS-1.
- AUX_EN, 1: if 1, the auxiliary group code 3'b100 is visited after the last colour group in every sweep.
- DWELL_CYCLES, 8: cycles each group stays selected; must be at least 1.
- SWEEP_W, 16: width of the sweep counters.
- clk  in  1: single clock.
- rst  in  1: synchronous, active-high reset.
- start  in  1: one-cycle request to begin a run; sampled only in IDLE.
- stop  in  1: request a graceful stop; sampled in RUN; sticky until the run ends.
- num_sweeps  in  SWEEP_W: sweeps to run, latched on start; 0 means run until stopped.
- group_EN  out  3 (bit order [0:2]): group code fed to the decoder.
- group_valid  out  1: high while group_EN is an active update phase; the core ANDs the decoded mask with it.
- sample_stb  out  1: one-cycle pulse at every sweep boundary.
- sweep_cnt  out  SWEEP_W: completed sweeps in the current run.
- busy  out  1: high from the cycle after start until DONE exits.
- done  out  1: one-cycle pulse when a run completes.

## Operation
- States: IDLE, RUN, SNAP, DONE.
- IDLE:
  - On start, latch num_sweeps, clear sweep_cnt, clear the stop flag, and go to RUN with group 0 and the dwell counter at 0.
  - start is ignored outside IDLE.
- RUN:
  - group_valid=1 and group_EN=current group.
  - The dwell counter counts 0 to DWELL_CYCLES-1. At terminal count it clears and the group advances: 0, 1, …, NUM_GROUPS-1, then 3'b100 if AUX_EN is set.
  - After the last group's terminal count, go to SNAP.
- SNAP lasts 1 cycle:
  - group_valid=0, sample_stb=1, sweep_cnt increments.
  - Go to DONE if stop is set, or if num_sweeps≠0 and the incremented count equals num_sweeps. Otherwise return to RUN at group 0.
- DONE lasts 1 cycle: done=1, group_valid=0, then go to IDLE.
- Outside RUN, group_EN holds its last value; it is never driven to an undecoded code.
- A stop asserted in any RUN cycle completes the current sweep, including its SNAP, before DONE. Sweeps are never truncated.
- sweep_cnt saturates at all-ones when num_sweeps=0. It holds its final value in IDLE until the next start.

## Timing
- Reset values: state=IDLE, group_EN=3'b000, group_valid=0, sample_stb=0, sweep_cnt=0, busy=0, done=0, dwell=0, stop flag=0.
- Reset mid-run forces the reset values in the next cycle with no done pulse.
- All outputs are registered.
- start at cycle t gives group_valid=1 and group_EN=0 at t+1.
- Sweep length is G·DWELL_CYCLES + 1 cycles, where G = NUM_GROUPS + AUX_EN.
- For N sweeps:
  - done pulses at t + N·(G·DWELL_CYCLES+1) + 1.
  - busy falls in the cycle after done.
- If stop and the final SNAP fall in the same cycle, there is a single DONE.
- start in the same cycle as done is ignored; start is accepted one cycle later.

## Structure
- Shared package gs_pkg holds:
  - the state enum;
  - the localparams for the group codes (GRP0..GRP3, GRP_AUX=3'b100);
  - the group-code width (3).
- One sub-module is natural: dwell_counter, a parameterised modulo-DWELL_CYCLES counter with clear/enable inputs and a terminal-count output. The FSM, group index and sweep counter stay in the top module.

## Test plan
- Reset, then start with num_sweeps=2, NUM_GROUPS=4, AUX_EN=1, DWELL_CYCLES=8 → group_EN sequence 0,1,2,3,4 (each held 8 cycles), then a SNAP. sample_stb pulses twice, sweep_cnt reaches 2, and done pulses at cycle start+83.
- num_sweeps=0, with stop asserted mid-group 2 of sweep 3 → sweep 3 completes, sweep_cnt=3 with sample_stb in the same cycle, then done 1 cycle later.
- DWELL_CYCLES=1, AUX_EN=0, num_sweeps=1 → group_EN 0,1,2,3 on consecutive cycles, SNAP at start+5, done at start+6.
- Assert rst while in RUN at group 2 → next cycle shows all outputs at reset values and no done pulse. A subsequent start works normally.
- start pulsed while busy, and again in the done cycle → both ignored, sweep_cnt undisturbed. A start one cycle after done begins a new run.
- Assertions run in every test:
  - group_valid is never 1 in SNAP, DONE or IDLE;
  - group_EN is always a valid code;
  - sample_stb is exactly 1 cycle wide.
